wci_ocp_worker_target: RTL and testbench

Synthesizable WCI::OCP target: the responder end of the WCI link that the initiator BFM drives. It decodes control-space operations into the worker control state machine. It serves config-space reads and writes from a byte-enabled register bank, and returns one response per accepted request. It is the reusable worker-side control endpoint and is intended to be instanced as the DUT in WCI test benches.

---
 rtl/wci_ocp_worker_target.sv | 184 ++++++++++++++++++
 tb/tb_wci_ocp_worker_target.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wci_ocp_worker_target.sv
// WCI::OCP worker-side control endpoint: control-space ops drive the worker lifecycle FSM,
// config-space ops access a byte-enabled register bank; one response per accepted request.
module wci_ocp_worker_target #(
  parameter int NREGS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wciS0_MReset_n,
  input  logic [2:0]  wciS0_MCmd,
  input  logic        wciS0_MAddrSpace,
  input  logic [3:0]  wciS0_MByteEn,
  input  logic [19:0] wciS0_MAddr,
  input  logic [31:0] wciS0_MData,
  output logic [1:0]  wciS0_SResp,
  output logic [31:0] wciS0_SData,
  output logic        wciS0_SThreadBusy,
  output logic [1:0]  wciS0_SFlag,
  input  logic [1:0]  wciS0_MFlag,
  output logic [1:0]  ctl_state
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_EXISTS = 2'd0,
    ST_INIT   = 2'd1,
    ST_OPER   = 2'd2,
    ST_SUSP   = 2'd3
  } ctl_state_t;

  ctl_state_t  state_q, state_d;

  logic        rst;
  logic        boot_q;
  logic        busy;
  logic        cmd_vld;
  logic        req_acc;
  logic        drop;

  logic        req_q;
  logic        req_wr_q;
  logic        req_space_q;
  logic [3:0]  req_be_q;
  logic [17:0] req_addr_q;
  logic [31:0] req_data_q;

  logic [1:0]  sresp_q, sresp_d;
  logic [31:0] sdata_q, sdata_d;
  logic        err_q;
  logic        wr_en;
  logic        legal;
  logic [2:0]  op;
  logic [IW-1:0] idx;

  logic [31:0] regs [NREGS];

  logic unused_ok;
  assign unused_ok = ^{wciS0_MFlag, wciS0_MAddr[1:0]};

  // Either reset source behaves identically.
  assign rst     = RST | ~wciS0_MReset_n;
  assign busy    = rst | boot_q | req_q | (sresp_q != RESP_NULL);
  assign cmd_vld = (wciS0_MCmd == 3'd1) || (wciS0_MCmd == 3'd2);
  assign req_acc = cmd_vld && !busy;
  assign drop    = cmd_vld && busy;

  assign op  = req_addr_q[2:0];
  assign idx = req_addr_q[IW-1:0];

  // Request capture (cycle N) and reset-hold of busy for one cycle after reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      boot_q      <= 1'b1;
      req_q       <= 1'b0;
      req_wr_q    <= 1'b0;
      req_space_q <= 1'b0;
      req_be_q    <= 4'd0;
      req_addr_q  <= 18'd0;
      req_data_q  <= 32'd0;
    end else begin
      boot_q <= 1'b0;
      req_q  <= req_acc;
      if (req_acc) begin
        req_wr_q    <= (wciS0_MCmd == 3'd1);
        req_space_q <= wciS0_MAddrSpace;
        req_be_q    <= wciS0_MByteEn;
        req_addr_q  <= wciS0_MAddr[19:2];
        req_data_q  <= wciS0_MData;
      end
    end
  end

  // Execute stage (cycle N+1): decode, next state and response.
  always_comb begin
    state_d = state_q;
    sresp_d = RESP_NULL;
    sdata_d = 32'd0;
    wr_en   = 1'b0;
    legal   = 1'b0;
    if (req_q) begin
      if (!req_space_q) begin
        if (req_wr_q) begin
          sresp_d = RESP_ERR;
        end else begin
          case (op)
            3'd0: if (state_q == ST_EXISTS) begin
                    legal   = 1'b1;
                    state_d = ST_INIT;
                  end
            3'd1: if (state_q == ST_INIT || state_q == ST_SUSP) begin
                    legal   = 1'b1;
                    state_d = ST_OPER;
                  end
            3'd2: if (state_q == ST_OPER) begin
                    legal   = 1'b1;
                    state_d = ST_SUSP;
                  end
            3'd3: if (state_q == ST_INIT || state_q == ST_SUSP) begin
                    legal   = 1'b1;
                    state_d = ST_EXISTS;
                  end
            3'd4: legal = (state_q == ST_INIT);
            3'd5, 3'd6: legal = (state_q != ST_EXISTS);
            default: legal = 1'b0;
          endcase
          if (legal) begin
            sresp_d = RESP_DVA;
            sdata_d = 32'hC0DE_4200 | {29'd0, op};
          end else begin
            sresp_d = RESP_ERR;
            sdata_d = 32'hC0DE_4E00 | {29'd0, op};
          end
        end
      end else begin
        if (req_addr_q >= 18'(NREGS) || state_q == ST_EXISTS) begin
          sresp_d = RESP_ERR;
        end else if (req_wr_q) begin
          wr_en   = 1'b1;
          sresp_d = RESP_DVA;
        end else begin
          sresp_d = RESP_DVA;
          sdata_d = regs[idx];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_EXISTS;
      sresp_q <= RESP_NULL;
      sdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sresp_q <= sresp_d;
      sdata_q <= sdata_d;
      if (sresp_d == RESP_ERR || drop)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= 32'd0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (req_be_q[b])
          regs[idx][8*b +: 8] <= req_data_q[8*b +: 8];
    end
  end

  assign wciS0_SResp       = sresp_q;
  assign wciS0_SData       = sdata_q;
  assign wciS0_SThreadBusy = busy;
  assign wciS0_SFlag       = {err_q, state_q == ST_OPER};
  assign ctl_state         = state_q;

endmodule

// File: tb/tb_wci_ocp_worker_target.sv
// Directed bench for wci_ocp_worker_target: lifecycle ops, config access, busy drops, reset.
module tb_wci_ocp_worker_target;

  localparam int NREGS = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wciS0_MReset_n = 1'b1;
  logic [2:0]  wciS0_MCmd = 3'd0;
  logic        wciS0_MAddrSpace = 1'b0;
  logic [3:0]  wciS0_MByteEn = 4'd0;
  logic [19:0] wciS0_MAddr = 20'd0;
  logic [31:0] wciS0_MData = 32'd0;
  logic [1:0]  wciS0_SResp;
  logic [31:0] wciS0_SData;
  logic        wciS0_SThreadBusy;
  logic [1:0]  wciS0_SFlag;
  logic [1:0]  wciS0_MFlag = 2'd0;
  logic [1:0]  ctl_state;

  int n_cmp = 0;
  int n_mis = 0;

  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic        r_busy1, r_busy2;
  logic [1:0]  r_state, r_flag;

  wci_ocp_worker_target #(.NREGS(NREGS)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .wciS0_MReset_n    (wciS0_MReset_n),
    .wciS0_MCmd        (wciS0_MCmd),
    .wciS0_MAddrSpace  (wciS0_MAddrSpace),
    .wciS0_MByteEn     (wciS0_MByteEn),
    .wciS0_MAddr       (wciS0_MAddr),
    .wciS0_MData       (wciS0_MData),
    .wciS0_SResp       (wciS0_SResp),
    .wciS0_SData       (wciS0_SData),
    .wciS0_SThreadBusy (wciS0_SThreadBusy),
    .wciS0_SFlag       (wciS0_SFlag),
    .wciS0_MFlag       (wciS0_MFlag),
    .ctl_state         (ctl_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reset pulse, then check reset outputs and the one-cycle busy hold afterwards.
  task automatic do_reset(input bit use_mreset);
    @(posedge CLK); #1;
    if (use_mreset) wciS0_MReset_n = 1'b0; else RST = 1'b1;
    wciS0_MCmd = 3'd0;
    @(posedge CLK); #1;
    chk("rst_sresp", 32'(wciS0_SResp), 32'd0);
    chk("rst_sdata", wciS0_SData, 32'd0);
    chk("rst_busy",  32'(wciS0_SThreadBusy), 32'd1);
    chk("rst_sflag", 32'(wciS0_SFlag), 32'd0);
    chk("rst_state", 32'(ctl_state), 32'd0);
    RST = 1'b0;
    wciS0_MReset_n = 1'b1;
    chk("rst_busy_hold", 32'(wciS0_SThreadBusy), 32'd1);
    @(posedge CLK); #1;
    chk("rst_busy_drop", 32'(wciS0_SThreadBusy), 32'd0);
  endtask

  // Issue one request at cycle N and capture outputs at N+1 and N+2.
  task automatic do_req(input logic [2:0] cmd, input logic space, input logic [19:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
    @(posedge CLK); #1;
    wciS0_MCmd = cmd; wciS0_MAddrSpace = space; wciS0_MAddr = addr;
    wciS0_MByteEn = be; wciS0_MData = data;
    @(posedge CLK); #1;
    wciS0_MCmd = 3'd0;
    r_busy1 = wciS0_SThreadBusy;
    @(posedge CLK); #1;
    r_resp = wciS0_SResp; r_data = wciS0_SData; r_busy2 = wciS0_SThreadBusy;
    r_state = ctl_state; r_flag = wciS0_SFlag;
  endtask

  task automatic ctl(input logic [2:0] op);
    do_req(3'd2, 1'b0, {15'd0, op, 2'b00}, 4'hF, 32'd0);
  endtask

  initial begin
    do_reset(1'b0);

    // Initialize from Exists.
    ctl(3'd0);
    chk("init_resp", 32'(r_resp), 32'd1);
    chk("init_data", r_data, 32'hC0DE_4200);
    chk("init_state", 32'(r_state), 32'd1);
    chk("init_busy1", 32'(r_busy1), 32'd1);
    chk("init_busy2", 32'(r_busy2), 32'd1);

    // Errors while in Exists.
    do_reset(1'b1);
    ctl(3'd1);
    chk("ex_start_resp", 32'(r_resp), 32'd3);
    chk("ex_start_data", r_data, 32'hC0DE_4E01);
    chk("ex_start_flag", 32'(r_flag), 32'd2);
    chk("ex_start_state", 32'(r_state), 32'd0);
    do_req(3'd1, 1'b1, 20'd0, 4'hF, 32'h1234_5678);
    chk("ex_cfgwr_resp", 32'(r_resp), 32'd3);
    chk("ex_cfgwr_data", r_data, 32'd0);
    chk("ex_cfgwr_state", 32'(r_state), 32'd0);

    // Byte-enabled write then read at the earliest slot.
    do_reset(1'b0);
    ctl(3'd0);
    do_req(3'd1, 1'b1, 20'd12, 4'b0101, 32'hDEAD_BEEF);
    chk("wr_resp", 32'(r_resp), 32'd1);
    chk("wr_data", r_data, 32'd0);
    do_req(3'd2, 1'b1, 20'd12, 4'b0000, 32'd0);
    chk("rd_resp", 32'(r_resp), 32'd1);
    chk("rd_data", r_data, 32'h00AD_00EF);
    chk("rd_flag", 32'(r_flag), 32'd0);
    @(posedge CLK); #1;
    chk("resp_one_cycle", 32'(wciS0_SResp), 32'd0);

    // Full lifecycle.
    ctl(3'd1);
    chk("start_data", r_data, 32'hC0DE_4201);
    chk("start_sflag0", 32'(r_flag[0]), 32'd1);
    chk("start_state", 32'(r_state), 32'd2);
    ctl(3'd2);
    chk("stop_data", r_data, 32'hC0DE_4202);
    chk("stop_sflag0", 32'(r_flag[0]), 32'd0);
    chk("stop_state", 32'(r_state), 32'd3);
    ctl(3'd1);
    chk("restart_resp", 32'(r_resp), 32'd1);
    chk("restart_sflag0", 32'(r_flag[0]), 32'd1);
    ctl(3'd2);
    chk("restop_resp", 32'(r_resp), 32'd1);
    chk("restop_sflag0", 32'(r_flag[0]), 32'd0);
    ctl(3'd3);
    chk("release_data", r_data, 32'hC0DE_4203);
    chk("release_state", 32'(r_state), 32'd0);
    chk("release_flag", 32'(r_flag), 32'd0);

    // Re-initialize: registers persist; boundary index and illegal ops.
    ctl(3'd0);
    do_req(3'd2, 1'b1, 20'(NREGS * 4), 4'hF, 32'd0);
    chk("oob_resp", 32'(r_resp), 32'd3);
    chk("oob_data", r_data, 32'd0);
    do_req(3'd1, 1'b1, 20'd12, 4'b0000, 32'hFFFF_FFFF);
    chk("be0_resp", 32'(r_resp), 32'd1);
    do_req(3'd2, 1'b1, 20'd12, 4'hF, 32'd0);
    chk("persist_data", r_data, 32'h00AD_00EF);
    ctl(3'd4);
    chk("test_resp", 32'(r_resp), 32'd1);
    chk("test_data", r_data, 32'hC0DE_4204);
    ctl(3'd7);
    chk("op7_resp", 32'(r_resp), 32'd3);
    chk("op7_data", r_data, 32'hC0DE_4E07);
    ctl(3'd2);
    chk("stop_init_data", r_data, 32'hC0DE_4E02);
    chk("stop_init_state", 32'(r_state), 32'd1);
    do_req(3'd1, 1'b0, 20'd0, 4'hF, 32'd0);
    chk("ctlwr_resp", 32'(r_resp), 32'd3);
    chk("ctlwr_data", r_data, 32'd0);

    // Request while busy is dropped and flagged.
    do_reset(1'b0);
    @(posedge CLK); #1;
    wciS0_MCmd = 3'd2; wciS0_MAddrSpace = 1'b0; wciS0_MAddr = 20'd0;
    @(posedge CLK); #1;
    chk("drop_busy", 32'(wciS0_SThreadBusy), 32'd1);
    wciS0_MAddrSpace = 1'b1;
    @(posedge CLK); #1;
    wciS0_MCmd = 3'd0;
    chk("drop_resp", 32'(wciS0_SResp), 32'd1);
    chk("drop_data", wciS0_SData, 32'hC0DE_4200);
    chk("drop_flag", 32'(wciS0_SFlag), 32'd2);
    @(posedge CLK); #1;
    chk("drop_no_resp1", 32'(wciS0_SResp), 32'd0);
    @(posedge CLK); #1;
    chk("drop_no_resp2", 32'(wciS0_SResp), 32'd0);

    // Reset arriving while a request is in flight discards it.
    wciS0_MCmd = 3'd2; wciS0_MAddrSpace = 1'b0; wciS0_MAddr = 20'd4;
    @(posedge CLK); #1;
    wciS0_MCmd = 3'd0; RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_sresp", 32'(wciS0_SResp), 32'd0);
    chk("midrst_sdata", wciS0_SData, 32'd0);
    chk("midrst_busy", 32'(wciS0_SThreadBusy), 32'd1);
    chk("midrst_sflag", 32'(wciS0_SFlag), 32'd0);
    chk("midrst_state", 32'(ctl_state), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    ctl(3'd0);
    do_req(3'd2, 1'b1, 20'd12, 4'hF, 32'd0);
    chk("regs_cleared", r_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
